// File: rtl/dp_autorange.sv
// ----------------------------------------------------------------------------
// dp_autorange : decimal-point placement, leading-zero blanking and auto-range
//                control for the frequency/period meter display.
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dp_autorange #(
  parameter int DIGITS = 4,
  parameter int RANGES = 4,
  parameter int RSEL_W = 2,
  parameter int HYST   = 2
) (
  input  logic                  clk,
  input  logic                  nRST,
  input  logic                  store,
  input  logic                  measure_mode,
  input  logic [1:0]            avg_dec,
  input  logic                  auto_en,
  input  logic [RSEL_W-1:0]     man_sel,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  ovf_in,
  output logic [RSEL_W-1:0]     range_sel,
  output logic [DIGITS-1:0]     dot_led,
  output logic [DIGITS-1:0]     blank,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  over,
  output logic                  upd
);

  // Signed width large enough for DIGITS-1 down to DIGITS-RANGES-3
  localparam int PW = $clog2(DIGITS + RANGES + 4) + 1;
  localparam int UW = $clog2(HYST + 1);
  localparam logic [RSEL_W-1:0] RMAX = RSEL_W'(RANGES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAP  = 2'd1,
    EVAL = 2'd2
  } state_t;

  state_t               state;
  logic                 store_d;
  logic                 skip;
  logic [UW-1:0]        under_cnt;
  logic [4*DIGITS-1:0]  cap_bcd;
  logic                 cap_ovf;

  logic                 store_edge;
  logic signed [PW-1:0] p;
  int                   pmax;
  logic                 lead;
  logic [DIGITS-1:0]    dot_nx;
  logic [DIGITS-1:0]    blank_nx;
  logic [RSEL_W-1:0]    man_c;
  logic                 msd_zero;

  assign store_edge = store & ~store_d;
  assign man_c      = (int'(man_sel) >= RANGES) ? RMAX : man_sel;
  assign msd_zero   = (cap_bcd[4*DIGITS-1 -: 4] == 4'd0);

  always_comb begin
    p        = PW'(DIGITS - 1) - PW'(range_sel) - (measure_mode ? PW'(avg_dec) : PW'(0));
    pmax     = (p < 0) ? 0 : int'(p);
    dot_nx   = '0;
    blank_nx = '0;
    lead     = 1'b1;
    // Scan from the MSD; blanking stops at the first non-zero digit or at the dot
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (int'(p) == i) dot_nx[i] = 1'b1;
      if (lead && (i > pmax) && (cap_bcd[4*i +: 4] == 4'd0)) blank_nx[i] = 1'b1;
      else lead = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      store_d   <= 1'b0;
      skip      <= 1'b0;
      under_cnt <= '0;
      cap_bcd   <= '0;
      cap_ovf   <= 1'b0;
      range_sel <= '0;
      dot_led   <= '0;
      blank     <= '0;
      bcd_out   <= '0;
      over      <= 1'b0;
      upd       <= 1'b0;
    end else begin
      store_d <= store;
      upd     <= 1'b0;
      case (state)
        IDLE: if (store_edge) state <= CAP;
        CAP: begin
          cap_bcd <= bcd_in;
          cap_ovf <= ovf_in;
          state   <= EVAL;
        end
        EVAL: begin
          state <= IDLE;
          if (skip) begin
            skip <= 1'b0;
          end else begin
            bcd_out <= cap_bcd;
            over    <= cap_ovf;
            dot_led <= dot_nx;
            blank   <= blank_nx;
            upd     <= 1'b1;
          end
          // Any range change discards the next result while the gate settles
          if (!auto_en) begin
            range_sel <= man_c;
            under_cnt <= '0;
            if (man_c != range_sel) skip <= 1'b1;
          end else if (cap_ovf) begin
            under_cnt <= '0;
            if (range_sel < RMAX) begin
              range_sel <= range_sel + 1'b1;
              skip      <= 1'b1;
            end
          end else if (msd_zero && (range_sel != '0)) begin
            if (int'(under_cnt) + 1 >= HYST) begin
              range_sel <= range_sel - 1'b1;
              skip      <= 1'b1;
              under_cnt <= '0;
            end else begin
              under_cnt <= under_cnt + 1'b1;
            end
          end else begin
            under_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dp_autorange.sv
// ----------------------------------------------------------------------------
// tb_dp_autorange : scoreboard bench for dp_autorange with directed vectors.
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dp_autorange;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic        store = 1'b0;
  logic        measure_mode = 1'b0;
  logic [1:0]  avg_dec = 2'd0;
  logic        auto_en = 1'b0;
  logic [1:0]  man_sel = 2'd0;
  logic [15:0] bcd_in = 16'h0;
  logic        ovf_in = 1'b0;
  logic [1:0]  range_sel;
  logic [3:0]  dot_led;
  logic [3:0]  blank;
  logic [15:0] bcd_out;
  logic        over;
  logic        upd;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  dot;
    logic [3:0]  blk;
    logic [15:0] bcd;
    logic        ovr;
    logic [1:0]  rng;
  } exp_t;

  exp_t q[$];

  dp_autorange #(.DIGITS(4), .RANGES(4), .RSEL_W(2), .HYST(2)) dut (
    .clk(clk), .nRST(nRST), .store(store), .measure_mode(measure_mode),
    .avg_dec(avg_dec), .auto_en(auto_en), .man_sel(man_sel), .bcd_in(bcd_in),
    .ovf_in(ovf_in), .range_sel(range_sel), .dot_led(dot_led), .blank(blank),
    .bcd_out(bcd_out), .over(over), .upd(upd)
  );

  always #5 clk = ~clk;

  // Monitor: every upd pulse must match the oldest expected result
  always @(negedge clk) begin
    if (upd) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL upd_unexpected: got dot=%b blank=%b bcd=%h over=%b rng=%0d, required no update",
                 dot_led, blank, bcd_out, over, range_sel);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (dot_led !== e.dot || blank !== e.blk || bcd_out !== e.bcd ||
            over !== e.ovr || range_sel !== e.rng) begin
          errors++;
          $display("FAIL upd_result: got dot=%b blank=%b bcd=%h over=%b rng=%0d, required dot=%b blank=%b bcd=%h over=%b rng=%0d",
                   dot_led, blank, bcd_out, over, range_sel, e.dot, e.blk, e.bcd, e.ovr, e.rng);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // One measurement: u=1 if an update is expected; r is range_sel after EVAL
  task automatic meas(input logic [15:0] b, input logic o, input bit u,
                      input logic [3:0] d, input logic [3:0] bl, input logic [1:0] r);
    exp_t e;
    bcd_in = b;
    ovf_in = o;
    if (u) begin
      e.dot = d; e.blk = bl; e.bcd = b; e.ovr = o; e.rng = r;
      q.push_back(e);
    end
    @(negedge clk) store = 1'b1;
    @(negedge clk) store = 1'b0;
    repeat (6) @(negedge clk);
    check("range_sel", 32'(range_sel), 32'(r));
  endtask

  task automatic drain;
    for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_range", 32'(range_sel), 32'd0);
    check("rst_dot",   32'(dot_led),   32'd0);
    check("rst_blank", 32'(blank),     32'd0);
    check("rst_bcd",   32'(bcd_out),   32'd0);
    check("rst_over",  32'(over),      32'd0);
    check("rst_upd",   32'(upd),       32'd0);
    nRST = 1'b1;
    repeat (2) @(negedge clk);

    // Manual ranges, frequency mode; first result after a change is skipped
    meas(16'h1234, 0, 1, 4'b1000, 4'b0000, 2'd0);
    man_sel = 2'd1;
    meas(16'h1234, 0, 1, 4'b1000, 4'b0000, 2'd1);
    meas(16'h1234, 0, 0, 4'b0000, 4'b0000, 2'd1);
    meas(16'h1234, 0, 1, 4'b0100, 4'b0000, 2'd1);
    man_sel = 2'd2;
    meas(16'h1234, 0, 1, 4'b0100, 4'b0000, 2'd2);
    meas(16'h1234, 0, 0, 4'b0000, 4'b0000, 2'd2);
    meas(16'h1234, 0, 1, 4'b0010, 4'b0000, 2'd2);
    man_sel = 2'd3;
    meas(16'h1234, 0, 1, 4'b0010, 4'b0000, 2'd3);
    meas(16'h1234, 0, 0, 4'b0000, 4'b0000, 2'd3);
    meas(16'h1234, 0, 1, 4'b0001, 4'b0000, 2'd3);
    meas(16'h0045, 0, 1, 4'b0001, 4'b1100, 2'd3);

    // Period mode, averaging shifts the dot off the display
    measure_mode = 1'b1; avg_dec = 2'd3; man_sel = 2'd1;
    meas(16'h0045, 0, 1, 4'b0000, 4'b1100, 2'd1);
    meas(16'h0045, 0, 0, 4'b0000, 4'b0000, 2'd1);
    meas(16'h0045, 0, 1, 4'b0000, 4'b1100, 2'd1);
    avg_dec = 2'd0;
    meas(16'h0045, 0, 1, 4'b0100, 4'b1000, 2'd1);
    measure_mode = 1'b0; man_sel = 2'd0;
    meas(16'h1234, 0, 1, 4'b0100, 4'b0000, 2'd0);
    meas(16'h1234, 0, 0, 4'b0000, 4'b0000, 2'd0);
    meas(16'h0045, 0, 1, 4'b1000, 4'b0000, 2'd0);

    // Auto: overflow steps up to the top range and holds there
    auto_en = 1'b1;
    meas(16'h9999, 1, 1, 4'b1000, 4'b0000, 2'd1);
    meas(16'h1234, 0, 0, 4'b0000, 4'b0000, 2'd1);
    meas(16'h9999, 1, 1, 4'b0100, 4'b0000, 2'd2);
    meas(16'h1234, 0, 0, 4'b0000, 4'b0000, 2'd2);
    meas(16'h9999, 1, 1, 4'b0010, 4'b0000, 2'd3);
    meas(16'h1234, 0, 0, 4'b0000, 4'b0000, 2'd3);
    meas(16'h9999, 1, 1, 4'b0001, 4'b0000, 2'd3);
    meas(16'h9999, 1, 1, 4'b0001, 4'b0000, 2'd3);

    // Auto: two under-range results step down
    meas(16'h0123, 0, 1, 4'b0001, 4'b1000, 2'd3);
    meas(16'h0123, 0, 1, 4'b0001, 4'b1000, 2'd2);
    meas(16'h1234, 0, 0, 4'b0000, 4'b0000, 2'd2);
    meas(16'h0123, 0, 1, 4'b0010, 4'b1000, 2'd2);
    meas(16'h0123, 0, 1, 4'b0010, 4'b1000, 2'd1);
    meas(16'h1234, 0, 0, 4'b0000, 4'b0000, 2'd1);
    // Under, normal, under: counter restarts, no change
    meas(16'h0123, 0, 1, 4'b0100, 4'b1000, 2'd1);
    meas(16'h1234, 0, 1, 4'b0100, 4'b0000, 2'd1);
    meas(16'h0123, 0, 1, 4'b0100, 4'b1000, 2'd1);
    drain();

    // Reset between CAP and EVAL loses the capture
    bcd_in = 16'h5678; ovf_in = 1'b0;
    @(negedge clk) store = 1'b1;
    @(posedge clk);
    @(negedge clk) store = 1'b0;
    @(posedge clk);
    #1 nRST = 1'b0;
    @(negedge clk);
    check("rst_mid_range", 32'(range_sel), 32'd0);
    check("rst_mid_dot",   32'(dot_led),   32'd0);
    check("rst_mid_blank", 32'(blank),     32'd0);
    check("rst_mid_bcd",   32'(bcd_out),   32'd0);
    check("rst_mid_over",  32'(over),      32'd0);
    nRST = 1'b1;
    repeat (6) @(negedge clk);

    // Second rise while busy is dropped: exactly one update
    q.push_back('{dot: 4'b1000, blk: 4'b0000, bcd: 16'h1234, ovr: 1'b0, rng: 2'd0});
    bcd_in = 16'h1234;
    @(negedge clk) store = 1'b1;
    @(negedge clk) store = 1'b0;
    @(negedge clk) store = 1'b1;
    @(negedge clk) store = 1'b0;
    repeat (8) @(negedge clk);
    drain();
    check("dbl_bcd", 32'(bcd_out), 32'h1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
